// File: rtl/axi_arb_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// axi_arb_pkg: shared types, widths and AW field offsets
// Revision: 1.0
// ------------------------------------------------------------------
package axi_arb_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   // Offsets of the fixed control fields above {addr,user,id}
   localparam int REGION_OFS = 0;
   localparam int QOS_OFS    = 4;
   localparam int LEN_OFS    = 8;
   localparam int SIZE_OFS   = 16;
   localparam int BURST_OFS  = 19;
   localparam int LOCK_OFS   = 21;
   localparam int PROT_OFS   = 22;
   localparam int CACHE_OFS  = 25;
   localparam int CTRL_WIDTH = 29;

   function automatic int aw_width(input int addr_w, input int user_w, input int id_w);
      return CTRL_WIDTH + addr_w + user_w + id_w;
   endfunction

   function automatic int sel_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

   function automatic int user_lsb(input int id_w);
      return id_w;
   endfunction

   function automatic int addr_lsb(input int id_w, input int user_w);
      return id_w + user_w;
   endfunction

   function automatic int ctrl_lsb(input int id_w, input int user_w, input int addr_w);
      return id_w + user_w + addr_w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/axi_sel_fifo.sv
`default_nettype none
// ------------------------------------------------------------------
// axi_sel_fifo: count-based FIFO of W-route slave indices, no bypass
// Revision: 1.0
// ------------------------------------------------------------------
module axi_sel_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_full,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data,
   input  logic             i_pop
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] c_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] c_FULL = CNT_W'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == c_FULL);
   assign o_valid = (r_count != '0);
   assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;

   // Full blocks push and empty ignores pop, so the count never leaves 0..DEPTH
   assign w_push = i_push && !o_full;
   assign w_pop  = i_pop && o_valid;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/axi_aw_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// axi_aw_arbiter: round-robin merge of AW channels with W-route FIFO
// Revision: 1.0
// ------------------------------------------------------------------
module axi_aw_arbiter
   import axi_arb_pkg::*;
#(
   parameter int NUM_SLAVES     = 2,
   parameter int ID_WIDTH       = 4,
   parameter int ADDR_WIDTH     = 32,
   parameter int USER_WIDTH     = 1,
   parameter int SEL_FIFO_DEPTH = 4,
   localparam int AW_WIDTH      = aw_width(ADDR_WIDTH, USER_WIDTH, ID_WIDTH),
   localparam int SEL_WIDTH     = sel_width(NUM_SLAVES)
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [NUM_SLAVES-1:0]          slave_valid_i,
   input  logic [NUM_SLAVES*AW_WIDTH-1:0] slave_data_i,
   output logic [NUM_SLAVES-1:0]          slave_ready_o,
   output logic                           master_valid_o,
   output logic [AW_WIDTH-1:0]            master_data_o,
   input  logic                           master_ready_i,
   output logic                           sel_valid_o,
   output logic [SEL_WIDTH-1:0]           sel_o,
   input  logic                           sel_ready_i
);

   localparam logic [SEL_WIDTH:0] c_NUM = (SEL_WIDTH + 1)'(NUM_SLAVES);

   state_t                r_state;
   logic [SEL_WIDTH-1:0]  r_rr_ptr;
   logic                  r_valid;
   logic [AW_WIDTH-1:0]   r_data;

   logic                  w_any;
   logic                  w_can_grant;
   logic                  w_fifo_full;
   logic [SEL_WIDTH:0]    w_cand;
   logic [SEL_WIDTH:0]    w_nxt;
   logic [SEL_WIDTH-1:0]  w_gnt_idx;
   logic [SEL_WIDTH-1:0]  w_next_ptr;
   logic [AW_WIDTH-1:0]   w_gnt_data;

   // Visit ports in order rr_ptr, rr_ptr+1, ... (mod N); first valid one wins
   always_comb begin
      w_any     = 1'b0;
      w_gnt_idx = '0;
      w_cand    = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         w_cand = {1'b0, r_rr_ptr} + (SEL_WIDTH + 1)'(i);
         if (w_cand >= c_NUM) begin
            w_cand = w_cand - c_NUM;
         end
         for (int j = 0; j < NUM_SLAVES; j++) begin
            if (!w_any && slave_valid_i[j] && (w_cand == (SEL_WIDTH + 1)'(j))) begin
               w_any     = 1'b1;
               w_gnt_idx = SEL_WIDTH'(j);
            end
         end
      end
   end

   always_comb begin
      w_nxt      = {1'b0, w_gnt_idx} + 1'b1;
      w_next_ptr = (w_nxt == c_NUM) ? '0 : w_nxt[SEL_WIDTH-1:0];
   end

   assign w_can_grant = !rst_i && w_any && !w_fifo_full &&
                        ((r_state == IDLE) || master_ready_i);

   always_comb begin
      w_gnt_data    = '0;
      slave_ready_o = '0;
      for (int j = 0; j < NUM_SLAVES; j++) begin
         if (w_gnt_idx == SEL_WIDTH'(j)) begin
            w_gnt_data       = slave_data_i[j*AW_WIDTH +: AW_WIDTH];
            slave_ready_o[j] = w_can_grant;
         end
      end
   end

   // A grant while HOLD can only occur on a master handshake, so data is replaced
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state  <= IDLE;
         r_rr_ptr <= '0;
         r_valid  <= 1'b0;
         r_data   <= '0;
      end else begin
         if (w_can_grant) begin
            r_rr_ptr <= w_next_ptr;
         end
         case (r_state)
            IDLE: begin
               if (w_can_grant) begin
                  r_state <= HOLD;
                  r_valid <= 1'b1;
                  r_data  <= w_gnt_data;
               end
            end
            HOLD: begin
               if (master_ready_i) begin
                  if (w_can_grant) begin
                     r_data <= w_gnt_data;
                  end else begin
                     r_state <= IDLE;
                     r_valid <= 1'b0;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign master_valid_o = r_valid;
   assign master_data_o  = r_data;

   axi_sel_fifo #(
      .DEPTH (SEL_FIFO_DEPTH),
      .WIDTH (SEL_WIDTH)
   ) u_sel_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .i_push  (w_can_grant),
      .i_data  (w_gnt_idx),
      .o_full  (w_fifo_full),
      .o_valid (sel_valid_o),
      .o_data  (sel_o),
      .i_pop   (sel_ready_i)
   );

endmodule
`default_nettype wire
